// File: rtl/floppy_pwm_decoder.sv
// -----------------------------------------------------------------------------
// floppy_pwm_decoder
//
// Recovers an 8-bit PCM level from a single-bit PWM audio stream. Each PWM
// frame begins at a rising edge of pwm_in. The decoder measures the frame's
// high time and length, and can optionally smooth the result with a
// first-order IIR filter. A line with no rising edges for TIMEOUT cycles is
// declared stalled. The decoder then reports idle with a full-scale level if
// the line is stuck high, or a zero level if it is stuck low.
//
// Parameters
//   AVG_SHIFT  IIR smoothing strength. 0 gives the raw frame value.
//              N gives an accumulator of 8+N bits.
//   TIMEOUT    Cycles since the last rising edge before the line is
//              declared stalled. Legal range is 4..255.
//
// Ports
//   clk           system clock; all logic updates on the rising edge
//   reset_n       synchronous active-low reset
//   pwm_in        PWM audio line; may be asynchronous to clk
//   sample        recovered level; held between strobes
//   sample_valid  one-cycle strobe; sample and period were just updated
//   period        length in clk cycles of the last frame; 0 after a timeout
//   idle          high while no frame is being tracked
// -----------------------------------------------------------------------------
module floppy_pwm_decoder #(
  parameter int unsigned AVG_SHIFT = 0,
  parameter int unsigned TIMEOUT   = 127
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pwm_in,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic [7:0] period,
  output logic       idle
);

  localparam int unsigned ACC_W       = 8 + AVG_SHIFT;
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

  // IDLE: no frame tracked.
  // SYNC: first (partial) frame after idle; it is discarded.
  // RUN:  every rise closes a complete frame.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s3_q, s3_d;
  logic [7:0]         per_cnt_q, per_cnt_d;
  logic [7:0]         hi_cnt_q, hi_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               valid_q, valid_d;
  logic [7:0]         period_q, period_d;
  logic               idle_q, idle_d;

  // Combinational helpers
  logic               rise;
  logic [7:0]         per_cnt_inc;
  logic [7:0]         hi_cnt_inc;
  logic [ACC_W-1:0]   acc_filt;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default value first.
  // This keeps any path from holding an old value, so no latches are inferred.
  always_comb begin
    // s1/s2 resynchronise the asynchronous line. s3 holds the previous
    // synchronised value, so a rise is detected in the first cycle s2 reads 1.
    s1_d = pwm_in;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;

    // Saturating increments keep a stalled line from wrapping the counters
    // back into a plausible frame length.
    per_cnt_inc = (per_cnt_q == 8'hFF) ? 8'hFF : per_cnt_q + 8'd1;
    hi_cnt_inc  = (hi_cnt_q  == 8'hFF) ? 8'hFF : hi_cnt_q  + 8'd1;

    // First-order IIR: acc tracks raw << AVG_SHIFT in steady state. When
    // AVG_SHIFT is 0 this reduces to acc = raw. The subtraction never goes
    // below zero, and the sum never overflows the 8+AVG_SHIFT bits, even
    // after an all-ones timeout load.
    acc_filt = acc_q - (acc_q >> AVG_SHIFT) + ACC_W'(hi_cnt_q);

    // The rise cycle is cycle 1 of the new frame. s2 is 1 there, so the
    // high count also restarts at 1.
    if (rise) begin
      per_cnt_d = 8'd1;
      hi_cnt_d  = 8'd1;
    end else begin
      per_cnt_d = per_cnt_inc;
      hi_cnt_d  = s2_q ? hi_cnt_inc : hi_cnt_q;
    end

    state_d  = state_q;
    valid_d  = 1'b0;
    period_d = period_q;
    idle_d   = idle_q;
    acc_d    = acc_q;

    unique case (state_q)
      ST_IDLE: begin
        // Leaving idle only arms tracking. The frame now starting is partial
        // from the decoder's point of view, so nothing is reported yet.
        if (rise) begin
          state_d = ST_SYNC;
          idle_d  = 1'b0;
        end
      end

      ST_SYNC, ST_RUN: begin
        if (rise) begin
          // Close the frame using the counter values from before the restart.
          // A rise on the same cycle as the timeout match takes priority.
          state_d  = ST_RUN;
          valid_d  = 1'b1;
          period_d = per_cnt_q;
          acc_d    = acc_filt;
        end else if (per_cnt_q == TIMEOUT_CNT) begin
          // Stalled line: report the level it is stuck at, bypassing the
          // filter, so the output settles at once rather than decaying.
          state_d  = ST_IDLE;
          valid_d  = 1'b1;
          period_d = 8'd0;
          idle_d   = 1'b1;
          acc_d    = s2_q ? {ACC_W{1'b1}} : {ACC_W{1'b0}};
        end
      end

      default: begin
        state_d = ST_IDLE;
        idle_d  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All flops then
  // sample their inputs from the same clock edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      per_cnt_q <= 8'd0;
      hi_cnt_q  <= 8'd0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      period_q  <= 8'd0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      period_q  <= period_d;
      idle_q    <= idle_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all come straight from registers
  // ---------------------------------------------------------------------------
  assign sample       = acc_q[AVG_SHIFT +: 8];
  assign sample_valid = valid_q;
  assign period       = period_q;
  assign idle         = idle_q;

endmodule

// File: tb/tb_floppy_pwm_decoder.sv
// -----------------------------------------------------------------------------
// tb_floppy_pwm_decoder
//
// Two decoders, one with AVG_SHIFT = 0 and one with AVG_SHIFT = 2, share the
// same pwm_in and reset_n. A reference model predicts every output on every
// cycle. It works from frame events: rises are located in the synchronised
// level stream, frame length and high time come from cycle-index differences,
// and the filter is plain integer arithmetic. Directed phases cover steady
// PWM, stalls high and low, period-2 frames, the TIMEOUT-length frame, and
// reset mid-frame. A random phase follows.
// -----------------------------------------------------------------------------
module tb_floppy_pwm_decoder;

  localparam int TIMEOUT = 127;
  localparam int SHIFT0  = 0;
  localparam int SHIFT2  = 2;

  logic       clk;
  logic       reset_n;
  logic       pwm_in;

  logic [7:0] smp0, per0, smp2, per2;
  logic       vld0, idl0, vld2, idl2;

  floppy_pwm_decoder #(.AVG_SHIFT(SHIFT0), .TIMEOUT(TIMEOUT)) u_avg0 (
    .clk          (clk),
    .reset_n      (reset_n),
    .pwm_in       (pwm_in),
    .sample       (smp0),
    .sample_valid (vld0),
    .period       (per0),
    .idle         (idl0)
  );

  floppy_pwm_decoder #(.AVG_SHIFT(SHIFT2), .TIMEOUT(TIMEOUT)) u_avg2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .pwm_in       (pwm_in),
    .sample       (smp2),
    .sample_valid (vld2),
    .period       (per2),
    .idle         (idl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_SYNC, M_RUN} mode_t;

  mode_t      m_mode;
  logic       d1, d2, d3;       // pin as seen 1, 2 and 3 clocks ago
  int         cyc;              // index of the cycle being evaluated
  int         last_rise;        // cycle index of the rise that opened the frame
  int         high_total;       // running count of synchronised-high cycles
  int         high_at_rise;     // high_total at the frame-opening rise
  int         m_acc [2];
  logic [7:0] e_samp [2];
  logic [7:0] e_period;
  logic       e_valid;
  logic       e_idle;
  bit         started = 0;

  function automatic int shift_of(input int i);
    return (i == 0) ? SHIFT0 : SHIFT2;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
      m_mode   = M_IDLE;
      e_valid  = 1'b0;
      e_period = 8'd0;
      e_idle   = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_acc[i]  = 0;
        e_samp[i] = 8'd0;
      end
    end else begin
      logic lvl;
      logic rise_now;
      int   per, hi;
      lvl      = d2;
      rise_now = d2 && !d3;
      e_valid  = 1'b0;
      if (rise_now) begin
        if (m_mode != M_IDLE) begin
          per = cyc - last_rise;            if (per > 255) per = 255;
          hi  = high_total - high_at_rise;  if (hi > 255)  hi  = 255;
          e_valid  = 1'b1;
          e_period = 8'(per);
          for (int i = 0; i < 2; i++) begin
            m_acc[i]  = m_acc[i] - (m_acc[i] >> shift_of(i)) + hi;
            e_samp[i] = 8'((m_acc[i] >> shift_of(i)) & 255);
          end
          m_mode = M_RUN;
        end else begin
          m_mode = M_SYNC;
          e_idle = 1'b0;
        end
        last_rise    = cyc;
        high_at_rise = high_total;
      end else if (m_mode != M_IDLE && (cyc - last_rise) == TIMEOUT) begin
        e_valid  = 1'b1;
        e_period = 8'd0;
        e_idle   = 1'b1;
        m_mode   = M_IDLE;
        for (int i = 0; i < 2; i++) begin
          m_acc[i]  = lvl ? ((1 << (8 + shift_of(i))) - 1) : 0;
          e_samp[i] = lvl ? 8'hFF : 8'h00;
        end
      end
      high_total += int'(lvl);
      cyc++;
      d3 = d2;
      d2 = d1;
      d1 = pwm_in;
    end
    started = 1;
  end

  // Outputs are compared with the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      check("a0_valid",  32'(vld0), 32'(e_valid));
      check("a0_sample", 32'(smp0), 32'(e_samp[0]));
      check("a0_period", 32'(per0), 32'(e_period));
      check("a0_idle",   32'(idl0), 32'(e_idle));
      check("a2_valid",  32'(vld2), 32'(e_valid));
      check("a2_sample", 32'(smp2), 32'(e_samp[1]));
      check("a2_period", 32'(per2), 32'(e_period));
      check("a2_idle",   32'(idl2), 32'(e_idle));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  task automatic frame(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  initial begin
    cyc = 0; last_rise = 0; high_total = 0; high_at_rise = 0;
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_sample", 32'(smp0), 32'h00);
    check("rst_valid",  32'(vld0), 32'h0);
    check("rst_period", 32'(per0), 32'h00);
    check("rst_idle",   32'(idl0), 32'h1);
    reset_n = 1'b1;
    drive(1'b0, 10);

    // Steady PWM: period 63, high 20. AVG_SHIFT = 2 has settled by the end.
    repeat (24) frame(20, 43);
    check("steady_a0_sample", 32'(smp0), 32'd20);
    check("steady_a0_period", 32'(per0), 32'd63);
    check("steady_a2_sample", 32'(smp2), 32'd20);
    check("steady_idle",      32'(idl0), 32'h0);

    // Stall high, then stall low.
    drive(1'b1, 200);
    check("stall_hi_sample", 32'(smp0), 32'hFF);
    check("stall_hi_a2",     32'(smp2), 32'hFF);
    check("stall_hi_period", 32'(per0), 32'h00);
    check("stall_hi_idle",   32'(idl0), 32'h1);
    drive(1'b0, 30);
    drive(1'b1, 10);
    drive(1'b0, 40);
    drive(1'b1, 10);
    drive(1'b0, 200);
    check("stall_lo_sample", 32'(smp0), 32'h00);
    check("stall_lo_period", 32'(per0), 32'h00);
    check("stall_lo_idle",   32'(idl0), 32'h1);

    // Minimum frame: 1 high, 1 low.
    repeat (30) frame(1, 1);
    check("p2_a0_sample", 32'(smp0), 32'd1);
    check("p2_a0_period", 32'(per0), 32'd2);
    check("p2_a2_sample", 32'(smp2), 32'd1);

    // A frame of exactly TIMEOUT cycles ends in a normal strobe.
    drive(1'b1, 30);
    drive(1'b0, 97);
    drive(1'b1, 5);
    drive(1'b0, 20);
    check("t127_period", 32'(per0), 32'd127);
    check("t127_sample", 32'(smp0), 32'd30);
    check("t127_idle",   32'(idl0), 32'h0);
    drive(1'b0, 120);

    // Random frames, including some longer than TIMEOUT.
    repeat (80) begin
      int p, h;
      p = int'($urandom_range(140, 2));
      h = int'($urandom_range(p - 1, 1));
      frame(h, p - h);
    end

    // Reset in the middle of a frame while in RUN.
    repeat (3) frame(20, 43);
    drive(1'b1, 10);
    drive(1'b0, 15);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_sample", 32'(smp0), 32'h00);
    check("midrst_valid",  32'(vld0), 32'h0);
    check("midrst_period", 32'(per0), 32'h00);
    check("midrst_idle",   32'(idl0), 32'h1);
    reset_n = 1'b1;
    drive(1'b0, 5);
    repeat (3) frame(20, 43);
    check("postrst_sample", 32'(smp0), 32'd20);
    check("postrst_period", 32'(per0), 32'd63);

    // pwm_in held high through reset release.
    pwm_in  = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 10);
    drive(1'b0, 20);
    repeat (2) frame(15, 48);

    drive(1'b0, 300);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog: the bench is clock-count driven, so this fires only if
  // simulation time runs far past the expected length.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

endmodule
